// File: rtl/apb_pkg.sv
// Shared types and default geometry for the APB register-file completer.
package apb_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 2;
  localparam int RO_ADDR    = (2 ** ADDR_W_DEF) - 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Writable registers below the top address plus a wrapping transfer counter
// that is readable at the top address.
module apb_regfile #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inc,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = '1;

  logic [DATA_W-1:0] mem_q [NREG-1];
  logic [DATA_W-1:0] mem_d [NREG-1];
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;

  // Next register contents: writes to the counter address are ignored.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (we && (waddr != TOP)) begin
      mem_d[waddr] = wdata;
    end
    if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Storage and counter flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG - 1; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  // Combinational read: counter at the top address, storage elsewhere.
  always_comb begin
    rdata = '0;
    if (raddr == TOP) begin
      rdata = cnt_q;
    end else begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/apb_modport_slave.sv
// APB3-style completer: latched setup, configurable wait states, sticky
// protocol/access error, registered response outputs.
module apb_modport_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslave_error
);

  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0]     WS_INIT = CW'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] TOP     = '1;

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              rf_we;
  logic              rf_inc;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              setup;
  logic              abort;
  logic              mismatch;

  assign setup    = pselx && !penable;
  assign abort    = !pselx || !penable;
  assign mismatch = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);

  apb_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset_n),
    .we    (rf_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .inc   (rf_inc),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // State register and transfer datapath flops.
  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      pready_q <= 1'b0;
      perr_q   <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      pready_q <= pready_d;
      perr_q   <= perr_d;
      prdata_q <= prdata_d;
    end
  end

  // Next-state logic: sampled setup opens a transfer; abort or completion closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (abort || pready_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic. The read port looks at paddr in IDLE so the
  // zero-wait response can be precomputed on the setup edge.
  always_comb begin
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    pready_d = 1'b0;
    perr_d   = 1'b0;
    prdata_d = '0;
    rf_we    = 1'b0;
    rf_inc   = 1'b0;
    rf_raddr = (state_q == ST_IDLE) ? paddr : addr_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          wcnt_d  = WS_INIT;
          err_d   = pwrite && (paddr == TOP);
          if (WAIT_STATES == 0) begin
            pready_d = 1'b1;
            perr_d   = err_d;
            prdata_d = (err_d || pwrite) ? '0 : rf_rdata;
          end
        end
      end
      ST_ACCESS: begin
        if (abort) begin
          err_d  = 1'b0;
          wcnt_d = '0;
        end else if (!pready_q) begin
          err_d  = err_q || mismatch;
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == CW'(1)) begin
            pready_d = 1'b1;
            perr_d   = err_d;
            prdata_d = (err_d || write_q) ? '0 : rf_rdata;
          end
        end else begin
          // Commit decision follows the error already reported to the requester.
          rf_we  = write_q && !err_q;
          rf_inc = 1'b1;
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign prdata       = prdata_q;
  assign pready       = pready_q;
  assign pslave_error = perr_q;

endmodule

// File: tb/tb_apb_modport_slave.sv
// Self-checking bench: one completer with one wait state (index 0) and one
// zero-wait completer (index 1) share all inputs except pselx.
module tb_apb_modport_slave;
  import apb_pkg::*;

  typedef struct {
    logic [1:0] rdata;
    logic       err;
    int         waits;
  } exp_t;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b1;
  logic [1:0] psel_v = '0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [1:0] paddr = '0;
  logic [1:0] pwdata = '0;
  logic [1:0] prdata_a, prdata_b;
  logic [1:0] pready_v;
  logic [1:0] perr_v;

  logic [1:0] regs_m [2][4];
  logic [1:0] cnt_m [2];
  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;

  always #5 pclk = ~pclk;

  apb_modport_slave #(.ADDR_W(2), .DATA_W(2), .WAIT_STATES(1)) u_ws1 (
    .pclk(pclk), .preset_n(preset_n), .pselx(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
    .pready(pready_v[0]), .pslave_error(perr_v[0])
  );

  apb_modport_slave #(.ADDR_W(2), .DATA_W(2), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .preset_n(preset_n), .pselx(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
    .pready(pready_v[1]), .pslave_error(perr_v[1])
  );

  function automatic logic [1:0] rd_of(input int d);
    return (d == 0) ? prdata_a : prdata_b;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4; a++) regs_m[d][a] = '0;
      cnt_m[d] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n = 1'b1;
    psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b0;
    clear_model();
  endtask

  // One transfer on DUT d; expected response pushed at setup, popped at pready.
  task automatic xfer(input int d, input logic wr, input logic [1:0] a,
                      input logic [1:0] wd, input int mut_addr);
    exp_t e, got_e;
    int   w;
    logic err;
    err = (wr && (a == 2'(RO_ADDR))) || ((mut_addr >= 0) && (2'(mut_addr) != a));
    e.rdata = (err || wr) ? 2'b00 : ((a == 2'(RO_ADDR)) ? cnt_m[d] : regs_m[d][a]);
    e.err   = err;
    e.waits = (d == 0) ? 1 : 0;
    sb.push_back(e);
    @(negedge pclk);
    psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    if (mut_addr >= 0) paddr = 2'(mut_addr);
    w = 0;
    while (pready_v[d] !== 1'b1 && w < 8) begin
      @(negedge pclk);
      w++;
    end
    got_e = sb.pop_front();
    tests++;
    if (w >= 8) begin
      fails++;
      $display("FAIL timeout d=%0d addr=%0d: pready never rose within 8 cycles", d, a);
    end else begin
      if (rd_of(d) !== got_e.rdata) begin
        fails++;
        $display("FAIL rdata d=%0d addr=%0d wr=%0b: got %b expected %b", d, a, wr, rd_of(d), got_e.rdata);
      end
      tests++;
      if (perr_v[d] !== got_e.err) begin
        fails++;
        $display("FAIL pslave_error d=%0d addr=%0d wr=%0b: got %b expected %b", d, a, wr, perr_v[d], got_e.err);
      end
      tests++;
      if (w !== got_e.waits) begin
        fails++;
        $display("FAIL wait_states d=%0d addr=%0d: got %0d expected %0d", d, a, w, got_e.waits);
      end
      if (wr && !err) regs_m[d][a] = wd;
      cnt_m[d] = cnt_m[d] + 2'd1;
    end
    @(negedge pclk);
    psel_v[d] = 1'b0; penable = 1'b0;
    tests++;
    if (pready_v[d] !== 1'b0) begin
      fails++;
      $display("FAIL pready_after_completion d=%0d: got %b expected 0", d, pready_v[d]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (pready_v[d] !== 1'b0 || perr_v[d] !== 1'b0 || rd_of(d) !== 2'b00) begin
        fails++;
        $display("FAIL reset_outputs d=%0d: got pready=%b err=%b rdata=%b expected 0 0 00",
                 d, pready_v[d], perr_v[d], rd_of(d));
      end
    end
    xfer(0, 1'b0, 2'd2, 2'b00, -1);
    xfer(1, 1'b0, 2'd3, 2'b00, -1);
  endtask

  task automatic test_write_read();
    do_reset();
    xfer(0, 1'b1, 2'd1, 2'b10, -1);
    xfer(0, 1'b0, 2'd1, 2'b00, -1);
    xfer(1, 1'b1, 2'd2, 2'b01, -1);
    xfer(1, 1'b0, 2'd2, 2'b00, -1);
  endtask

  task automatic test_ro_write();
    do_reset();
    xfer(0, 1'b1, 2'd3, 2'b11, -1);
    xfer(0, 1'b0, 2'd3, 2'b00, -1);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    xfer(0, 1'b1, 2'd0, 2'b11, -1);
    xfer(0, 1'b0, 2'd0, 2'b00, -1);
    xfer(0, 1'b1, 2'd2, 2'b10, -1);
    xfer(0, 1'b0, 2'd1, 2'b00, -1);
    xfer(0, 1'b1, 2'd1, 2'b01, -1);
    tests++;
    if (cnt_m[0] !== 2'b01) begin
      fails++;
      $display("FAIL model_counter: got %b expected 01", cnt_m[0]);
    end
    xfer(0, 1'b0, 2'd3, 2'b00, -1);
  endtask

  task automatic test_addr_change();
    do_reset();
    xfer(0, 1'b1, 2'd0, 2'b11, 2);
    xfer(0, 1'b0, 2'd0, 2'b00, -1);
    xfer(0, 1'b0, 2'd2, 2'b00, -1);
  endtask

  // Setup a write of 2'b01 to addr 0, then drop pselx in the first ACCESS cycle.
  task automatic test_abort(input int d);
    do_reset();
    @(negedge pclk);
    psel_v[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 2'b01;
    @(negedge pclk);
    tests++;
    if (pready_v[d] !== ((d == 1) ? 1'b1 : 1'b0)) begin
      fails++;
      $display("FAIL abort_first_access_pready d=%0d: got %b expected %b", d, pready_v[d], (d == 1));
    end
    psel_v[d] = 1'b0;
    @(negedge pclk);
    tests++;
    if (pready_v[d] !== 1'b0 || perr_v[d] !== 1'b0 || rd_of(d) !== 2'b00) begin
      fails++;
      $display("FAIL abort_cleared d=%0d: got pready=%b err=%b rdata=%b expected 0 0 00",
               d, pready_v[d], perr_v[d], rd_of(d));
    end
    xfer(d, 1'b0, 2'd0, 2'b00, -1);
    xfer(d, 1'b0, 2'd3, 2'b00, -1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    xfer(1, 1'b1, 2'd1, 2'b10, -1);
    @(negedge pclk);
    psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd2; pwdata = 2'b11;
    @(negedge pclk);
    penable = 1'b1;
    tests++;
    if (pready_v[1] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre_pready: got %b expected 1", pready_v[1]);
    end
    #2 preset_n = 1'b1;
    #1;
    tests++;
    if (pready_v[1] !== 1'b0 || perr_v[1] !== 1'b0 || prdata_b !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_async: got pready=%b err=%b rdata=%b expected 0 0 00",
               pready_v[1], perr_v[1], prdata_b);
    end
    @(negedge pclk);
    psel_v = '0; penable = 1'b0; pwrite = 1'b0;
    preset_n = 1'b0;
    clear_model();
    xfer(1, 1'b0, 2'd2, 2'b00, -1);
    xfer(1, 1'b0, 2'd3, 2'b00, -1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ro_write();
    test_counter_wrap();
    test_addr_change();
    test_abort(0);
    test_abort(1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
